// File: rtl/gate_identifier.sv
// gate_identifier: identifies an unknown 2-input gate under test. It steps the
// gate inputs through 00, 01, 10, 11 and holds each vector for SETTLE_CYCLES
// cycles before sampling Y. The four samples form a truth table (bit index =
// {A,B}), and the table is decoded into a gate code that is held until the
// next run completes.
module gate_identifier #(
  // Cycles each vector is held before Y is sampled; legal range 1..255.
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       Y,
  output logic       A,
  output logic       B,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth,
  output logic [2:0] gate_code
);

  // The settle counter only has to reach SETTLE_CYCLES-1.
  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SETTLE_CYCLES - 1);

  localparam logic [2:0] CodeAnd     = 3'd0;
  localparam logic [2:0] CodeOr      = 3'd1;
  localparam logic [2:0] CodeNand    = 3'd2;
  localparam logic [2:0] CodeNor     = 3'd3;
  localparam logic [2:0] CodeXor     = 3'd4;
  localparam logic [2:0] CodeXnor    = 3'd5;
  localparam logic [2:0] CodeUnknown = 3'd7;

  typedef enum logic [1:0] {
    StIdle,
    StApply,
    StSample
  } state_e;

  state_e          state;
  logic [1:0]      idx;
  logic [CntW-1:0] cnt;

  // Map a captured truth table (bit index = {A,B}) to a gate code. Code 6 is
  // reserved; constant tables and anything non-standard fall to UNKNOWN.
  function automatic logic [2:0] decode(input logic [3:0] tt);
    logic [2:0] code;
    case (tt)
      4'b1000: code = CodeAnd;
      4'b1110: code = CodeOr;
      4'b0111: code = CodeNand;
      4'b0001: code = CodeNor;
      4'b0110: code = CodeXor;
      4'b1001: code = CodeXnor;
      default: code = CodeUnknown;
    endcase
    return code;
  endfunction

  // Sequencer: applies the four vectors, samples Y on each SAMPLE cycle and
  // publishes the decoded result with a one-cycle done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      idx       <= 2'd0;
      cnt       <= '0;
      A         <= 1'b0;
      B         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      truth     <= 4'b0000;
      gate_code <= CodeUnknown;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          A    <= 1'b0;
          B    <= 1'b0;
          busy <= 1'b0;
          // The done cycle is already IDLE, so a held start re-triggers here
          // and consecutive runs follow with no gap.
          if (start) begin
            idx   <= 2'd0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= StApply;
          end
        end

        StApply: begin
          if (cnt == CntLast) begin
            state <= StSample;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        StSample: begin
          truth[idx] <= Y;
          if (idx != 2'd3) begin
            idx      <= idx + 2'd1;
            {A, B}   <= idx + 2'd1;
            cnt      <= '0;
            state    <= StApply;
          end else begin
            // The last sample is still in flight, so decode it directly
            // alongside the three bits already captured.
            done      <= 1'b1;
            busy      <= 1'b0;
            {A, B}    <= 2'b00;
            idx       <= 2'd0;
            gate_code <= decode({Y, truth[2:0]});
            state     <= StIdle;
          end
        end

        default: begin
          state <= StIdle;
          busy  <= 1'b0;
          A     <= 1'b0;
          B     <= 1'b0;
        end
      endcase
    end
  end

  // Structural invariants of the sequencer.
  a_done_not_busy : assert property (@(posedge clk) disable iff (!rst_n) done |-> !busy);
  a_busy_state    : assert property (@(posedge clk) disable iff (!rst_n)
                                     busy == (state != StIdle));
  a_idle_inputs   : assert property (@(posedge clk) disable iff (!rst_n)
                                     (state == StIdle) |-> (!A && !B));
  a_no_code6      : assert property (@(posedge clk) disable iff (!rst_n) gate_code != 3'd6);

endmodule
